ma_trend_signal: RTL and testbench

- Sink for the averaged-price AXI-Stream that the moving-average filter produces.
- Compares each averaged price with the previous one and applies a hysteresis threshold to emit a trade action: HOLD, BUY or SELL.
- Tracks a FLAT/LONG/SHORT position.
- Forwards one output beat per accepted input beat (1:1) to the order-generation stage.

---
 rtl/ma_trend_signal.sv | 182 ++++++++++++++++++
 tb/tb_ma_trend_signal.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ma_trend_signal.sv
// Trend-following action generator: compares each averaged price with the previous one,
// applies a hysteresis threshold, tracks FLAT/LONG/SHORT and forwards one action beat per input beat.
module ma_trend_signal #(
    parameter int unsigned THRESH = 4,
    parameter int unsigned WARMUP = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             s_aclk,
    input  logic             s_aresetn,
    input  logic             s_axis_tvalid,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic             m_axis_tvalid,
    output logic [31:0]      m_axis_tdata,
    output logic [1:0]       m_axis_tuser,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic [1:0]       position,
    output logic [CNT_W-1:0] buy_cnt,
    output logic [CNT_W-1:0] sell_cnt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned SC_W   = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

    localparam logic [1:0] ACT_HOLD  = 2'b00;
    localparam logic [1:0] ACT_BUY   = 2'b01;
    localparam logic [1:0] ACT_SELL  = 2'b10;
    localparam logic [1:0] POS_FLAT  = 2'b00;
    localparam logic [1:0] POS_LONG  = 2'b01;
    localparam logic [1:0] POS_SHORT = 2'b10;

    localparam logic signed [DIFF_W-1:0] THR_P   = DIFF_W'(THRESH);
    localparam logic signed [DIFF_W-1:0] THR_N   = -THR_P;
    localparam logic [SC_W-1:0]          SC_MAX  = SC_W'(WARMUP);
    localparam logic [CNT_W-1:0]         CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t              r_state,      w_state;
    logic [DATA_W-1:0]   r_data,       w_data;
    logic                r_last,       w_last;
    logic [DATA_W-1:0]   r_prev,       w_prev;
    logic [SC_W-1:0]     r_sample_cnt, w_sample_cnt;
    logic [1:0]          r_position,   w_position;
    logic                r_s_tready,   w_s_tready;
    logic                r_m_tvalid,   w_m_tvalid;
    logic [DATA_W-1:0]   r_m_tdata,    w_m_tdata;
    logic [1:0]          r_m_tuser,    w_m_tuser;
    logic                r_m_tlast,    w_m_tlast;
    logic [CNT_W-1:0]    r_buy_cnt,    w_buy_cnt;
    logic [CNT_W-1:0]    r_sell_cnt,   w_sell_cnt;

    logic signed [DIFF_W-1:0] w_delta;
    logic signed [DIFF_W-1:0] w_delta_eff;

    // 33-bit signed difference so a full-range swing never wraps
    assign w_delta     = $signed({1'b0, r_data}) - $signed({1'b0, r_prev});
    assign w_delta_eff = (r_sample_cnt == '0) ? '0 : w_delta;

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            r_state      <= ST_IDLE;
            r_data       <= '0;
            r_last       <= 1'b0;
            r_prev       <= '0;
            r_sample_cnt <= '0;
            r_position   <= POS_FLAT;
            r_s_tready   <= 1'b0;
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tuser    <= ACT_HOLD;
            r_m_tlast    <= 1'b0;
            r_buy_cnt    <= '0;
            r_sell_cnt   <= '0;
        end else begin
            r_state      <= w_state;
            r_data       <= w_data;
            r_last       <= w_last;
            r_prev       <= w_prev;
            r_sample_cnt <= w_sample_cnt;
            r_position   <= w_position;
            r_s_tready   <= w_s_tready;
            r_m_tvalid   <= w_m_tvalid;
            r_m_tdata    <= w_m_tdata;
            r_m_tuser    <= w_m_tuser;
            r_m_tlast    <= w_m_tlast;
            r_buy_cnt    <= w_buy_cnt;
            r_sell_cnt   <= w_sell_cnt;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_data       = r_data;
        w_last       = r_last;
        w_prev       = r_prev;
        w_sample_cnt = r_sample_cnt;
        w_position   = r_position;
        w_s_tready   = r_s_tready;
        w_m_tvalid   = r_m_tvalid;
        w_m_tdata    = r_m_tdata;
        w_m_tuser    = r_m_tuser;
        w_m_tlast    = r_m_tlast;
        w_buy_cnt    = r_buy_cnt;
        w_sell_cnt   = r_sell_cnt;

        case (r_state)
            ST_IDLE: begin
                w_s_tready = 1'b1;
                if (s_axis_tvalid && r_s_tready) begin
                    w_data     = s_axis_tdata;
                    w_last     = s_axis_tlast;
                    w_s_tready = 1'b0;
                    w_state    = ST_EVAL;
                end
            end

            ST_EVAL: begin
                w_m_tuser = ACT_HOLD;
                // Warmup masks actions while the upstream filter is still filling
                if (r_sample_cnt >= SC_MAX) begin
                    if ((w_delta_eff > THR_P) && (r_position != POS_LONG)) begin
                        w_m_tuser  = ACT_BUY;
                        w_position = POS_LONG;
                    end else if ((w_delta_eff < THR_N) && (r_position != POS_SHORT)) begin
                        w_m_tuser  = ACT_SELL;
                        w_position = POS_SHORT;
                    end
                end
                if ((w_m_tuser == ACT_BUY) && (r_buy_cnt != CNT_MAX)) begin
                    w_buy_cnt = r_buy_cnt + CNT_W'(1);
                end
                if ((w_m_tuser == ACT_SELL) && (r_sell_cnt != CNT_MAX)) begin
                    w_sell_cnt = r_sell_cnt + CNT_W'(1);
                end
                if (r_sample_cnt < SC_MAX) begin
                    w_sample_cnt = r_sample_cnt + SC_W'(1);
                end
                w_prev     = r_data;
                w_m_tdata  = r_data;
                w_m_tlast  = r_last;
                w_m_tvalid = 1'b1;
                w_state    = ST_SEND;
            end

            ST_SEND: begin
                if (r_m_tvalid && m_axis_tready) begin
                    w_m_tvalid = 1'b0;
                    w_s_tready = 1'b1;
                    w_state    = ST_IDLE;
                    // Session boundary: restart warmup and flatten, counters persist
                    if (r_m_tlast) begin
                        w_prev       = '0;
                        w_sample_cnt = '0;
                        w_position   = POS_FLAT;
                    end
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tlast  = r_m_tlast;
    assign position      = r_position;
    assign buy_cnt       = r_buy_cnt;
    assign sell_cnt      = r_sell_cnt;

endmodule

// File: tb/tb_ma_trend_signal.sv
// Directed bench for ma_trend_signal (WARMUP=2, THRESH=4) with hand-computed expectations.
module tb_ma_trend_signal;

    localparam int unsigned CNT_W = 16;
    localparam logic [1:0] HOLD  = 2'b00;
    localparam logic [1:0] BUY   = 2'b01;
    localparam logic [1:0] SELL  = 2'b10;
    localparam logic [1:0] FLAT  = 2'b00;
    localparam logic [1:0] LONG  = 2'b01;
    localparam logic [1:0] SHORT = 2'b10;

    logic             s_aclk;
    logic             s_aresetn;
    logic             s_axis_tvalid;
    logic [31:0]      s_axis_tdata;
    logic             s_axis_tlast;
    logic             s_axis_tready;
    logic             m_axis_tvalid;
    logic [31:0]      m_axis_tdata;
    logic [1:0]       m_axis_tuser;
    logic             m_axis_tlast;
    logic             m_axis_tready;
    logic [1:0]       position;
    logic [CNT_W-1:0] buy_cnt;
    logic [CNT_W-1:0] sell_cnt;

    int n_tests;
    int n_fail;
    int hs_cnt;

    ma_trend_signal #(
        .THRESH (4),
        .WARMUP (2),
        .CNT_W  (CNT_W)
    ) dut (
        .s_aclk        (s_aclk),
        .s_aresetn     (s_aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .position      (position),
        .buy_cnt       (buy_cnt),
        .sell_cnt      (sell_cnt)
    );

    initial s_aclk = 1'b0;
    always #5 s_aclk = ~s_aclk;

    // Inputs only change #1 after posedge, so the preceding negedge sees the handshake values
    always @(negedge s_aclk) begin
        if (m_axis_tvalid && m_axis_tready) hs_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_aclk);
        #1;
    endtask

    // One full beat with downstream always ready; n counts cycles from the accept cycle
    task automatic xfer(input string tag, input logic [31:0] d, input logic l,
                        input logic [1:0] act, input logic [1:0] pos,
                        input int b, input int s);
        int n;
        n = 0;
        while (!s_axis_tready && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("%s.in_ready", tag), s_axis_tready, 1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        n = 1;
        while (!m_axis_tvalid && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("%s.latency", tag), n, 2);
        chk($sformatf("%s.tdata", tag), m_axis_tdata, d);
        chk($sformatf("%s.tuser", tag), m_axis_tuser, act);
        chk($sformatf("%s.tlast", tag), m_axis_tlast, l);
        chk($sformatf("%s.position", tag), position, pos);
        chk($sformatf("%s.buy_cnt", tag), buy_cnt, b);
        chk($sformatf("%s.sell_cnt", tag), sell_cnt, s);
        tick();
        chk($sformatf("%s.tvalid_drop", tag), m_axis_tvalid, 0);
        chk($sformatf("%s.ready_back", tag), s_axis_tready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hs0;
        int n;
        n_tests       = 0;
        n_fail        = 0;
        hs_cnt        = 0;
        s_aresetn     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst.s_tready", s_axis_tready, 0);
        chk("rst.m_tvalid", m_axis_tvalid, 0);
        chk("rst.m_tdata", m_axis_tdata, 0);
        chk("rst.m_tuser", m_axis_tuser, 0);
        chk("rst.m_tlast", m_axis_tlast, 0);
        chk("rst.position", position, 0);
        chk("rst.buy_cnt", buy_cnt, 0);
        chk("rst.sell_cnt", sell_cnt, 0);
        s_aresetn = 1'b1;
        tick();
        chk("rst.ready_first_clk", s_axis_tready, 1);

        // Warmup, buy, threshold edges, same-direction hold, full-range swings
        xfer("w100",  32'd100,        1'b0, HOLD, FLAT,  0, 0);
        xfer("w200",  32'd200,        1'b0, HOLD, FLAT,  0, 0);
        xfer("b210",  32'd210,        1'b0, BUY,  LONG,  1, 0);
        xfer("h220",  32'd220,        1'b0, HOLD, LONG,  1, 0);
        xfer("e224",  32'd224,        1'b0, HOLD, LONG,  1, 0);
        xfer("s219",  32'd219,        1'b0, SELL, SHORT, 1, 1);
        xfer("h0",    32'd0,          1'b0, HOLD, SHORT, 1, 1);
        xfer("bmax",  32'hFFFF_FFFF,  1'b0, BUY,  LONG,  2, 1);
        xfer("smin",  32'd0,          1'b0, SELL, SHORT, 2, 2);

        // Backpressure: extra input offered while the output beat is stalled
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'd5;
        tick();
        s_axis_tdata  = 32'd77;
        n = 0;
        while (!m_axis_tvalid && n < 20) begin
            tick();
            n++;
        end
        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d.m_tvalid", i), m_axis_tvalid, 1);
            chk($sformatf("bp%0d.m_tdata", i), m_axis_tdata, 5);
            chk($sformatf("bp%0d.s_tready", i), s_axis_tready, 0);
            tick();
        end
        chk("bp.tuser", m_axis_tuser, BUY);
        chk("bp.position", position, LONG);
        chk("bp.buy_cnt", buy_cnt, 3);
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0;
        tick();
        chk("bp.tvalid_drop", m_axis_tvalid, 0);
        tick();
        chk("bp.one_beat", hs_cnt - hs0, 1);
        chk("bp.no_extra", m_axis_tvalid, 0);

        // Session end restarts warmup and flattens; counters persist
        xfer("last300", 32'd300, 1'b1, HOLD, LONG, 3, 2);
        chk("last.pos_flat", position, FLAT);
        xfer("n400",    32'd400, 1'b0, HOLD, FLAT, 3, 2);

        // Asynchronous reset while a beat is pending
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'd500;
        tick();
        s_axis_tvalid = 1'b0;
        n = 0;
        while (!m_axis_tvalid && n < 20) begin
            tick();
            n++;
        end
        chk("arst.pending", m_axis_tvalid, 1);
        #2;
        s_aresetn = 1'b0;
        #1;
        chk("arst.tvalid_drop", m_axis_tvalid, 0);
        chk("arst.buy_cnt", buy_cnt, 0);
        chk("arst.sell_cnt", sell_cnt, 0);
        chk("arst.position", position, FLAT);
        tick();
        s_aresetn     = 1'b1;
        m_axis_tready = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
